// File: rtl/code_sender.sv
// code_sender: serial MSB-first code transmitter with repetition count,
// inter-repetition idle gap and a one-cycle completion pulse.
module code_sender #(
    parameter int CODE_W     = 4,
    parameter int GAP_CYCLES = 2,
    parameter int REP_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    input  logic [REP_W-1:0]  reps,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic              out,
    output logic              out_valid,
    output logic              done
);
    localparam int BW = $clog2(CODE_W);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t            state, state_d;
    logic [CODE_W-1:0] sh, code_q;
    logic [BW-1:0]     bit_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              last_bit, more;

    assign last_bit = bit_cnt == '0;
    assign more     = rep_cnt > REP_W'(1);

    always_comb begin
        state_d   = state;
        ready     = state == IDLE;
        busy      = state != IDLE;
        out_valid = state == SEND;
        out       = state == SEND && sh[CODE_W-1];
        done      = state == DONE;
        case (state)
            IDLE: if (start && !abort) state_d = reps != '0 ? SEND : DONE;
            SEND: if (abort) state_d = IDLE;
                  else if (last_bit) state_d = !more ? DONE : GAP_CYCLES > 0 ? GAP : SEND;
            GAP:  if (abort) state_d = IDLE;
                  else if (gap_cnt == '0) state_d = SEND;
            default: state_d = IDLE;
        endcase
    end

    // Datapath follows the current state; abort simply abandons it, the next start reloads everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sh      <= '0;
            code_q  <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: if (start && !abort) begin
                    code_q  <= code;
                    sh      <= code;
                    bit_cnt <= BW'(CODE_W - 1);
                    rep_cnt <= reps;
                end
                SEND: begin
                    sh      <= last_bit && GAP_CYCLES == 0 ? code_q : sh << 1;
                    bit_cnt <= last_bit ? BW'(CODE_W - 1) : bit_cnt - BW'(1);
                    if (last_bit) begin
                        rep_cnt <= rep_cnt == '0 ? '0 : rep_cnt - REP_W'(1);
                        gap_cnt <= GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GW'(1);
                    if (gap_cnt == '0) sh <= code_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_code_sender.sv
// tb_code_sender: randomized scoreboard bench; expected bit/done events are
// timestamped from the transfer timing rules and checked by a monitor.
module tb_code_sender;
    localparam int W = 4, G = 2, RW = 4;

    logic          clk = 0, rst = 0, start = 0, abort = 0;
    logic [W-1:0]  code = '0;
    logic [RW-1:0] reps = '0;
    logic          ready, busy, out, out_valid, done;

    code_sender #(.CODE_W(W), .GAP_CYCLES(G), .REP_W(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .code(code), .reps(reps), .abort(abort),
        .ready(ready), .busy(busy), .out(out), .out_valid(out_valid), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; bit dn; bit b;} exp_t;
    exp_t q[$];
    int cyc = 0, lo = -1, hi = -2, n_chk = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
        end
    endtask

    // Monitor: window [lo,hi] is when the model says the sender is busy.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("ready", ready, !(cyc >= lo && cyc <= hi));
            chk("busy", busy, cyc >= lo && cyc <= hi);
            if (!out_valid) chk("out_idle_zero", out, 0);
            if (out_valid || done) begin
                chk("expected_pending", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("done_flag", done, e.dn);
                    if (!e.dn) chk("out_bit", out, e.b);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            abort = 1'($urandom);
            @(posedge clk); #1;
        end
        abort = 0;
    endtask

    // Called at posedge+1 with the sender idle; ab>0 aborts at edge T+ab.
    task automatic xfer(input logic [W-1:0] c, input logic [RW-1:0] r, input int ab, input bit noise);
        int t, d, a, endc;
        start = 1; code = c; reps = r; abort = 0;
        t = cyc + 1;
        d = r == 0 ? 1 : int'(r) * W + (int'(r) - 1) * G + 1;
        a = ab > 0 ? t + ab : t + d + 1000;
        for (int k = 0; k < int'(r); k++)
            for (int j = 0; j < W; j++)
                if (t + k * (W + G) + j < a) q.push_back('{t + k * (W + G) + j, 1'b0, c[W-1-j]});
        if (ab == 0) q.push_back('{t + d - 1, 1'b1, 1'b0});
        endc = ab > 0 ? a - 1 : t + d - 1;
        lo = t; hi = endc;
        @(posedge clk); #1;
        start = 0;
        while (cyc < endc) begin
            if (noise) begin
                start = 1'($urandom);
                code  = W'($urandom);
                reps  = RW'($urandom);
            end
            @(posedge clk); #1;
        end
        abort = ab > 0 ? 1'b1 : noise & 1'($urandom);
        start = noise ? 1'($urandom) : 1'b0;
        @(posedge clk); #1;
        start = 0; abort = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_out"}, out, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int r, d, ab, t;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1;
        xfer(4'b1011, 1, 0, 0);
        idle(2);
        xfer(4'b1011, 2, 0, 0);
        xfer(4'b0110, 0, 0, 0);
        xfer(4'b1011, 2, 3, 0);
        xfer(4'b1011, 1, 0, 0);
        xfer(4'b1011, 2, 0, 1);
        xfer(4'b1111, 15, 0, 0);
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 4);
            d  = r == 0 ? 1 : r * W + (r - 1) * G + 1;
            ab = (r > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, d - 1) : 0;
            xfer(W'($urandom), RW'(r), ab, 1'($urandom));
            idle($urandom_range(0, 2));
        end
        // Asynchronous reset in the middle of a transfer.
        start = 1; code = 4'b1011; reps = 3;
        t = cyc + 1;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < W; j++) q.push_back('{t + k * (W + G) + j, 1'b0, code[W-1-j]});
        lo = t; hi = t + 1000;
        @(posedge clk); #1;
        start = 0;
        repeat (2) @(posedge clk);
        #3;
        chk("pre_reset_valid", out_valid, 1);
        rst = 0;
        #1;
        chk_reset_outputs("async_reset");
        q.delete();
        lo = -1; hi = -2;
        @(posedge clk); #1;
        rst = 1;
        xfer(4'b1011, 1, 0, 0);
        idle(3);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
